pipeline_hold_ctrl: RTL and testbench
=====================================

Name: pipeline_hold_ctrl

Overview:
Consumes hazard and flush requests and drives the hold, flush and bubble controls of the 5-stage MIPS pipeline registers and the PC. Requests come from three sources: the load-use `stall` from hazard detection, branch/jump resolution in EX, and data-memory wait. It adds two pieces of state: a memory-wait timeout watchdog and saturating performance counters. It sits between the hazard/branch logic and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- CNT_W, 16: width of each performance counter.
- WAIT_MAX, 15: consecutive `mem_wait` cycles tolerated before timeout; range 1..255.

Ports:
- clk, input, 1: pipeline clock.
- rst, input, 1: reset, asynchronous, active-high.
- stall, input, 1: load-use hazard request from hazard detection.
- branch_taken, input, 1: branch/jump resolved taken in EX.
- mem_wait, input, 1: data memory not ready; the MEM stage cannot complete.
- pc_write, output, 1: PC load enable.
- if_id_write, output, 1: IF/ID load enable.
- if_id_flush, output, 1: IF/ID cleared to NOP on the next edge.
- id_ex_write, output, 1: ID/EX load enable.
- id_ex_flush, output, 1: ID/EX loaded with a bubble (control zeroed).
- ex_mem_write, output, 1: EX/MEM load enable.
- mem_wb_bubble, output, 1: MEM/WB loaded with a bubble.
- mem_timeout, output, 1: sticky error flag.
- state, output, 2: current state; RUN=0, HOLD=1, FAULT=2.
- stall_cycles, output, CNT_W: count of load-use stall cycles.
- flush_count, output, CNT_W: count of taken-branch flushes.
- wait_cycles, output, CNT_W: count of memory-wait cycles.

Behaviour:
- State is registered. The control outputs are combinational from state and inputs: zero added latency, and each output acts on the same clock edge it is asserted.
- Reset, async, while rst=1:
  - state=RUN, wait counter=0, mem_timeout=0, all perf counters=0.
  - All write enables=0 and all flush/bubble outputs=0.
- Default, when no request is active: all write enables=1, all flush/bubble outputs=0.
- Request priority is mem_wait > branch_taken > stall.
- mem_wait=1, in RUN or HOLD (freeze):
  - pc_write=if_id_write=id_ex_write=ex_mem_write=0.
  - mem_wb_bubble=1.
  - branch_taken and stall are ignored; they are still asserted after the freeze because the stages hold.
- branch_taken=1 with mem_wait=0:
  - if_id_flush=1 and id_ex_flush=1.
  - All write enables=1, so the PC loads the target.
  - A simultaneous stall is ignored because the stalled instruction is squashed.
- stall=1 with mem_wait=0 and branch_taken=0:
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - id_ex_write=1 and ex_mem_write=1.
- Flush outputs are single-cycle by construction; each lasts only while its input is high.
- FSM transitions:
  - RUN -> HOLD when mem_wait=1; the wait counter loads 1.
  - HOLD with mem_wait=1: the wait counter increments.
  - HOLD -> FAULT when the counter equals WAIT_MAX and mem_wait=1.
  - HOLD -> RUN when mem_wait=0; the counter clears, and that cycle is a normal RUN-priority cycle.
  - FAULT is terminal until rst: mem_timeout=1, pipeline frozen exactly as in the mem_wait case regardless of inputs, counters frozen.
  - Any rst assertion mid-operation returns to RUN immediately.
- Timeout boundary: the FAULT transition happens on the edge ending the (WAIT_MAX+1)th consecutive wait cycle. Exactly WAIT_MAX consecutive wait cycles followed by mem_wait=0 must not fault.
- Counters:
  - Each counter increments by 1 per qualifying cycle, using the post-priority decision.
  - stall_cycles counts cycles where the stall action is taken.
  - flush_count counts cycles where the flush action is taken.
  - wait_cycles counts cycles with mem_wait=1 outside FAULT.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- The wait counter is ceil(log2(WAIT_MAX+1)) bits; it is never compared past WAIT_MAX.

Test Plan:
- Load-use: single-cycle stall=1, other inputs 0.
  - That cycle: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1.
  - Next cycle: defaults restored.
  - stall_cycles=1.
- Stall and branch_taken together for 1 cycle:
  - if_id_flush=1, id_ex_flush=1, pc_write=1.
  - flush_count=1, stall_cycles=0.
- mem_wait=1 for 3 cycles with stall=1 held throughout:
  - All write enables 0 and mem_wb_bubble=1 for 3 cycles; state=HOLD.
  - Then the stall action occurs in the RUN cycle.
  - wait_cycles=3.
- WAIT_MAX=15:
  - 15 wait cycles then mem_wait=0: no fault; back in RUN.
  - 16 consecutive wait cycles: state=FAULT, mem_timeout=1, pipeline frozen even after mem_wait=0.
- From FAULT, assert rst asynchronously mid-cycle: outputs drop immediately, mem_timeout=0, counters=0, state=RUN.
- CNT_W=4: apply 20 stall cycles; stall_cycles saturates at 15 and does not wrap.

Source files
------------

// File: rtl/pipeline_hold_ctrl.sv
// pipeline_hold_ctrl
// Turns load-use, taken-branch and data-memory-wait requests into the hold,
// flush and bubble controls of the 5-stage pipeline registers and the PC.
// The state is registered. The controls are combinational, so each one acts
// on the same edge at which it is asserted.
// A watchdog latches a sticky fault if the memory wait lasts too long.
// Three saturating counters record stall, flush and wait activity.
module pipeline_hold_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_cycles
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // The wait counter only needs to reach WAIT_MAX.
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic [CNT_W-1:0]  r_wait_cycles;

    logic w_fault;
    logic w_freeze;
    logic w_flush_act;
    logic w_stall_act;
    logic w_wait_act;

    // Post-priority decision: freeze beats flush, and flush beats stall.
    // A faulted controller freezes the pipeline whatever its inputs are.
    always_comb begin
        w_fault     = (r_state == ST_FAULT);
        w_freeze    = w_fault | mem_wait;
        w_flush_act = ~w_freeze & branch_taken;
        w_stall_act = ~w_freeze & ~branch_taken & stall;
        w_wait_act  = ~w_fault & mem_wait;
    end

    // Pipeline controls. They are all held inactive while reset is asserted.
    always_comb begin
        pc_write      = ~rst & ~w_freeze & ~w_stall_act;
        if_id_write   = ~rst & ~w_freeze & ~w_stall_act;
        if_id_flush   = ~rst & w_flush_act;
        id_ex_write   = ~rst & ~w_freeze;
        id_ex_flush   = ~rst & (w_flush_act | w_stall_act);
        ex_mem_write  = ~rst & ~w_freeze;
        mem_wb_bubble = ~rst & w_freeze;
    end

    // Watchdog FSM. The wait counter holds the number of consecutive wait
    // cycles seen so far. A further wait cycle at WAIT_MAX is one too many.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_wait) begin
                        r_state    <= ST_HOLD;
                        r_wait_cnt <= WCNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!mem_wait) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WCNT_MAX) begin
                        r_state   <= ST_FAULT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_ONE;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters. They advance on the decision that
    // was actually taken, so they stop once the controller has faulted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_wait_cycles  <= '0;
        end else begin
            if (w_stall_act && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_flush_act && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
            if (w_wait_act && (r_wait_cycles != '1)) begin
                r_wait_cycles <= r_wait_cycles + CNT_ONE;
            end
        end
    end

    // Status outputs come straight from the registers.
    always_comb begin
        state        = r_state;
        mem_timeout  = r_timeout;
        stall_cycles = r_stall_cycles;
        flush_count  = r_flush_count;
        wait_cycles  = r_wait_cycles;
    end

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Testbench for pipeline_hold_ctrl.
// Directed scenarios plus randomized stimulus, checked every cycle against
// a behavioural model built from the request rules.
module tb_pipeline_hold_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             branch_taken;
    logic             mem_wait;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] wait_cycles;

    pipeline_hold_ctrl #(
        .CNT_W   (CNT_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .mem_wait     (mem_wait),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout  (mem_timeout),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .wait_cycles  (wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_fault;
    int m_run_len;      // consecutive wait cycles so far
    int m_stalls;
    int m_flushes;
    int m_waits;
    int cyc = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x < CMAX) ? x + 1 : x;
    endfunction

    task automatic model_reset();
        m_fault   = 0;
        m_run_len = 0;
        m_stalls  = 0;
        m_flushes = 0;
        m_waits   = 0;
    endtask

    // The expected controls, packed in the order
    // {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, bubble}.
    function automatic int exp_ctrl();
        if (rst) return 7'b000_0000;
        if (m_fault || mem_wait) return 7'b000_0001;
        if (branch_taken) return 7'b111_1110;
        if (stall) return 7'b000_1110;
        return 7'b110_1010;
    endfunction

    task automatic compare_all();
        int exp_state;
        exp_state = m_fault ? 2 : ((m_run_len > 0) ? 1 : 0);
        check_val("ctrl", int'({pc_write, if_id_write, if_id_flush, id_ex_write,
                                id_ex_flush, ex_mem_write, mem_wb_bubble}), exp_ctrl());
        check_val("state", int'(state), exp_state);
        check_val("mem_timeout", int'(mem_timeout), int'(m_fault));
        check_val("stall_cycles", int'(stall_cycles), m_stalls);
        check_val("flush_count", int'(flush_count), m_flushes);
        check_val("wait_cycles", int'(wait_cycles), m_waits);
    endtask

    // Advance the model by one clock edge, using the inputs of that cycle.
    task automatic model_edge(input logic s, input logic b, input logic m);
        if (rst) begin
            model_reset();
        end else if (!m_fault) begin
            if (m) begin
                m_waits   = sat_inc(m_waits);
                m_run_len = m_run_len + 1;
                if (m_run_len == WAIT_MAX + 1) m_fault = 1;
            end else begin
                m_run_len = 0;
                if (b) m_flushes = sat_inc(m_flushes);
                else if (s) m_stalls = sat_inc(m_stalls);
            end
        end
    endtask

    // Each cycle starts 1 time unit after a rising edge. The outputs are
    // checked mid-cycle, and the model then steps on the next rising edge.
    task automatic step(input logic s, input logic b, input logic m);
        stall = s;
        branch_taken = b;
        mem_wait = m;
        #4;
        compare_all();
        $display("cyc=%0d rst=%0b stall=%0b br=%0b mw=%0b -> ctrl=%07b state=%0d to=%0b cnt=%0d/%0d/%0d",
                 cyc, rst, s, b, m,
                 {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble},
                 state, mem_timeout, stall_cycles, flush_count, wait_cycles);
        @(posedge clk);
        model_edge(s, b, m);
        cyc++;
        #1;
    endtask

    // Raise reset in the middle of a cycle and confirm that its effect is
    // immediate. Reset is then released away from any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_ctrl_zero", int'({pc_write, if_id_write, if_id_flush, id_ex_write,
                                         id_ex_flush, ex_mem_write, mem_wb_bubble}), 0);
        compare_all();
        $display("cyc=%0d async reset asserted: state=%0d to=%0b", cyc, state, mem_timeout);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        int seg;
        int len;
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        mem_wait = 1'b0;
        model_reset();
        #3;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use: a single stall cycle, after which the defaults return.
        step(1, 0, 0);
        step(0, 0, 0);
        check_val("load_use_count", int'(stall_cycles), 1);

        // Stall together with a taken branch: the flush wins.
        async_reset();
        step(1, 1, 0);
        step(0, 0, 0);
        check_val("br_stall_flush", int'(flush_count), 1);
        check_val("br_stall_nostall", int'(stall_cycles), 0);

        // Three wait cycles with stall held. The stall is acted on afterwards.
        async_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        step(1, 0, 0);
        check_val("wait3_count", int'(wait_cycles), 3);

        // Exactly WAIT_MAX wait cycles must not fault.
        async_reset();
        for (int i = 0; i < WAIT_MAX; i++) step(0, 0, 1);
        step(0, 0, 0);
        check_val("wmax_no_fault", int'(state), 0);

        // WAIT_MAX+1 wait cycles fault. The fault persists after mem_wait drops.
        for (int i = 0; i < WAIT_MAX + 1; i++) step(0, 0, 1);
        check_val("fault_state", int'(state), 2);
        step(0, 0, 0);
        step(1, 1, 0);

        // Async reset out of the fault.
        async_reset();
        check_val("after_rst_state", int'(state), 0);

        // Twenty stall cycles: the counter saturates instead of wrapping.
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        check_val("stall_sat", int'(stall_cycles), CMAX);

        // Randomized segments: mixed traffic, wait bursts near the
        // timeout boundary, and occasional resets.
        async_reset();
        for (int n = 0; n < 120; n++) begin
            seg = int'($urandom_range(0, 9));
            if (seg < 6) begin
                len = int'($urandom_range(1, 12));
                for (int i = 0; i < len; i++)
                    step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            end else if (seg < 9) begin
                len = int'($urandom_range(WAIT_MAX - 2, WAIT_MAX + 2));
                for (int i = 0; i < len; i++)
                    step(1'($urandom), 1'($urandom), 1'b1);
                step(1'($urandom), 1'($urandom), 1'b0);
            end else begin
                async_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
